ps2_rx_mem: RTL and testbench
=============================

# ps2_rx_mem

PS/2 keyboard receiver with a memory-mapped byte register interface, sitting directly upstream of `plic_mem`. It deserialises 11-bit PS/2 device-to-host frames and validates parity, start and stop bits. Valid scancodes go into a small FIFO readable by the CPU over the same byte bus the PLIC uses. Each accepted scancode produces a one-cycle `o_ps2_interrupt` pulse, which drives `plic_mem.i_ps2_interrupt`.

## Interface
- `FIFO_DEPTH`, 8: scancode FIFO entries; power of two, 2..64.
- `TIMEOUT_CYCLES`, 50000: `i_clk` cycles without a PS/2 falling edge before an in-progress frame is abandoned (1 ms at 50 MHz).
- `i_clk` input 1: single system clock; all logic on its rising edge.
- `i_rst` input 1: reset, synchronous, active-high.
- `i_ps2_clk` input 1: raw PS/2 clock line, asynchronous.
- `i_ps2_data` input 1: raw PS/2 data line, asynchronous.
- `i_data` input 8: write data.
- `i_address` input 24: byte address; the bus has already decoded `i_request` for this block.
- `i_write` input 1: 1 = write, 0 = read; qualified by `i_request`.
- `i_request` input 1: one-cycle access strobe.
- `o_data` output 8: registered read data.
- `o_data_DV` output 1: one-cycle completion strobe.
- `o_ps2_interrupt` output 1: one-cycle pulse per scancode pushed.

## Operation
- Register map (all other addresses: reads return 0x00, writes are ignored):
  - 0x202000 DATA (R): returns the FIFO head and pops it. When empty, returns 0x00 and pops nothing.
  - 0x202001 STATUS (R): bit0 not-empty, bit1 full, bit2 overflow (sticky), bit3 parity error (sticky), bit4 frame error (sticky), bits 7:5 = 0.
  - 0x202002 CONTROL (W): bit0=1 clears all three sticky flags; bit1=1 flushes the FIFO. Reads return 0x00.
  - 0x202003 COUNT (R): current FIFO occupancy, zero-extended.
- Input conditioning:
  - `i_ps2_clk` and `i_ps2_data` each pass through a 2-FF synchroniser.
  - A falling edge is synced clk 1 -> 0 against a 1-cycle history register.
- Receive FSM, advanced only on a detected falling edge or on timeout:
  - IDLE: on an edge with synced data 0 (start bit), go to RECV with bitcnt=0. An edge with data 1 is ignored.
  - RECV: shift data bits LSB-first. Edges 1-8 are data, edge 9 is parity, edge 10 is stop.
  - After the stop edge, go to CHECK.
  - Timeout counter clears on every edge while in RECV. When it reaches TIMEOUT_CYCLES: set frame error, go to IDLE, discard partial data.
  - CHECK (one cycle), then IDLE:
    - Stop = 0: set frame error.
    - Else parity not odd (XOR of 8 data bits and parity bit ≠ 1): set parity error.
    - Else, FIFO full: set overflow; drop the byte; no interrupt.
    - Else: push the byte and pulse `o_ps2_interrupt`.
- FIFO: circular buffer with pointers of width log2(FIFO_DEPTH) and a count of width log2(FIFO_DEPTH)+1.
  - Push and pop in the same cycle: both take effect, count unchanged.
  - Flush wins over a same-cycle push and pop; the pushed byte is discarded.
  - A push when full is dropped even if a pop occurs in the same cycle.
- Sticky flags: a set event in the same cycle as a clear leaves the flag set.
- Reset: FSM IDLE, FIFO empty, flags 0, timeout counter 0, synchronisers and edge history 1. `o_data`=0x00, `o_data_DV`=0, `o_ps2_interrupt`=0.

## Timing
- Access with `i_request` at cycle N: `o_data` is loaded and `o_data_DV`=1 at N+1.
  - `o_data` holds its value until the next read.
  - A write also produces `o_data_DV` at N+1 and leaves `o_data` unchanged.
- DATA pop and CONTROL effects apply at the N edge, so STATUS/COUNT read at N+1 reflect them.
- Back-to-back requests are accepted every cycle.
- A raw PS/2 falling edge is detected 3 cycles later: 2 synchroniser stages plus edge compare.
- CHECK is the cycle after the stop-bit edge is detected.
- Push and the `o_ps2_interrupt` pulse are registered at the end of CHECK, so COUNT increments in the same cycle the pulse is high.
- `i_rst` mid-frame aborts the frame with no flag set.

## Test plan
- Send frame for 0x1C (start 0, data LSB-first, parity 0, stop 1) -> exactly one `o_ps2_interrupt` pulse; COUNT=1. Read 0x202000 -> `o_data`=0x1C with DV one cycle after request; COUNT=0.
- Send 0xF0 with the parity bit inverted -> no pulse, FIFO empty, STATUS=0x08. Write 0x01 to 0x202002 -> STATUS=0x00.
- Send 9 valid frames (0x01..0x09) with FIFO_DEPTH=8 -> 8 pulses; STATUS bit1 and bit2 set. DATA reads return 0x01..0x08, then 0x00.
- Stop sending after 5 data bits and wait TIMEOUT_CYCLES+5 -> STATUS bit4 set. A following valid 0x2A frame is received correctly.
- Issue a DATA read in the same cycle as the CHECK push with COUNT=3 -> COUNT stays 3; the head is returned; order is preserved.
- Assert `i_rst` mid-frame, then send 0x55 -> all outputs 0 after reset; 0x55 is received with STATUS=0x01.

Source files
------------

// File: rtl/ps2_rx_mem_if.sv
// ps2_rx_mem_if: byte register bus between the CPU-side decoder and ps2_rx_mem.
//   i_data     [7:0]  write data            (master -> slave)
//   i_address  [23:0] byte address          (master -> slave)
//   i_write           1 = write, 0 = read   (master -> slave)
//   i_request         one-cycle strobe      (master -> slave)
//   o_data     [7:0]  registered read data  (slave -> master)
//   o_data_DV         completion strobe     (slave -> master)
interface ps2_rx_mem_if;
  logic [7:0]  i_data;
  logic [23:0] i_address;
  logic        i_write;
  logic        i_request;
  logic [7:0]  o_data;
  logic        o_data_DV;

  modport master (output i_data, i_address, i_write, i_request,
                  input  o_data, o_data_DV);
  modport slave  (input  i_data, i_address, i_write, i_request,
                  output o_data, o_data_DV);
endinterface

// File: rtl/ps2_rx_mem.sv
// ps2_rx_mem: PS/2 device-to-host receiver with a scancode FIFO behind a
// byte register bus. Frames are start/8 data LSB-first/odd parity/stop.
// Ports:
//   i_clk, i_rst        system clock, synchronous active-high reset
//   i_ps2_clk/data      raw asynchronous PS/2 lines
//   o_ps2_interrupt     one-cycle pulse per scancode pushed into the FIFO
//   bus                 register bus (DATA/STATUS/CONTROL/COUNT at 0x202000..3)
module ps2_rx_mem #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ps2_clk,
  input  logic            i_ps2_data,
  output logic            o_ps2_interrupt,
  ps2_rx_mem_if.slave     bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [23:0] A_DATA   = 24'h202000;
  localparam logic [23:0] A_STATUS = 24'h202001;
  localparam logic [23:0] A_CTRL   = 24'h202002;
  localparam logic [23:0] A_COUNT  = 24'h202003;

  // ---------------- input conditioning ----------------
  logic [1:0] clk_sync, data_sync;
  logic       clk_hist;
  logic       fall, din;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_hist  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], i_ps2_clk};
      data_sync <= {data_sync[0], i_ps2_data};
      clk_hist  <= clk_sync[1];
    end
  end

  assign fall = clk_hist & ~clk_sync[1];
  assign din  = data_sync[1];

  // ---------------- receive FSM ----------------
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;
  state_t state, state_nxt;

  logic [3:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par_bit, stop_bit;
  logic [TW-1:0] tcnt;
  logic          timeout;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      S_IDLE:  if (fall && !din) state_nxt = S_RECV;
      S_RECV: begin
        if (fall) begin
          if (bitcnt == 4'd9) state_nxt = S_CHECK;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_CHECK: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // bitcnt counts edges after the start bit: 0..7 data, 8 parity, 9 stop
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bitcnt   <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      stop_bit <= 1'b0;
      tcnt     <= '0;
    end else if (state == S_RECV) begin
      if (fall) begin
        tcnt   <= '0;
        bitcnt <= bitcnt + 4'd1;
        if (bitcnt < 4'd8)       shreg    <= {din, shreg[7:1]};
        else if (bitcnt == 4'd8) par_bit  <= din;
        else                     stop_bit <= din;
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end else begin
      bitcnt <= '0;
      tcnt   <= '0;
    end
  end

  // ---------------- bus decode ----------------
  logic [CW-1:0] count;
  logic          full, empty;
  logic          rd, wr, pop, clr, flush;
  logic          unused_ctrl_bits;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign rd    = bus.i_request & ~bus.i_write;
  assign wr    = bus.i_request &  bus.i_write;
  assign pop   = rd & (bus.i_address == A_DATA) & ~empty;
  assign clr   = wr & (bus.i_address == A_CTRL) & bus.i_data[0];
  assign flush = wr & (bus.i_address == A_CTRL) & bus.i_data[1];
  assign unused_ctrl_bits = ^bus.i_data[7:2];

  // ---------------- frame check ----------------
  logic in_check, frame_bad, par_bad, ovf_ev, push;
  assign in_check  = (state == S_CHECK);
  assign frame_bad = in_check & ~stop_bit;
  assign par_bad   = in_check & stop_bit & ~(^{shreg, par_bit});
  // fullness is judged before any same-cycle pop, so a full FIFO drops the byte
  assign ovf_ev    = in_check & stop_bit & (^{shreg, par_bit}) & full;
  assign push      = in_check & stop_bit & (^{shreg, par_bit}) & ~full;

  // ---------------- FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;

  always_ff @(posedge i_clk) begin
    if (!i_rst && push && !flush) mem[wp] <= shreg;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // ---------------- sticky flags ----------------
  logic ovf_flag, par_flag, frm_flag;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovf_flag <= 1'b0;
      par_flag <= 1'b0;
      frm_flag <= 1'b0;
    end else begin
      ovf_flag <= ovf_ev               | (ovf_flag & ~clr);
      par_flag <= par_bad              | (par_flag & ~clr);
      frm_flag <= frame_bad | timeout  | (frm_flag & ~clr);
    end
  end

  // ---------------- read data / outputs ----------------
  logic [7:0] rdata;

  always_comb begin
    rdata = 8'h00;
    case (bus.i_address)
      A_DATA:   rdata = empty ? 8'h00 : mem[rp];
      A_STATUS: rdata = {3'b000, frm_flag, par_flag, ovf_flag, full, ~empty};
      A_COUNT:  rdata = 8'(count);
      default:  rdata = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bus.o_data      <= 8'h00;
      bus.o_data_DV   <= 1'b0;
      o_ps2_interrupt <= 1'b0;
    end else begin
      if (rd) bus.o_data <= rdata;
      bus.o_data_DV   <= bus.i_request;
      o_ps2_interrupt <= push & ~flush;
    end
  end
endmodule

// File: tb/tb_ps2_rx_mem.sv
// tb_ps2_rx_mem: directed PS/2 frames and register accesses. A queue-based
// model predicts register reads and interrupt counts; a negedge process
// compares every bus completion against it, and literal expectations pin it.
module tb_ps2_rx_mem;
  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int HALF  = 8;
  localparam logic [23:0] A_DATA   = 24'h202000;
  localparam logic [23:0] A_STATUS = 24'h202001;
  localparam logic [23:0] A_CTRL   = 24'h202002;
  localparam logic [23:0] A_COUNT  = 24'h202003;

  logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic irq;

  ps2_rx_mem_if bus();

  ps2_rx_mem #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
    .o_ps2_interrupt(irq), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // model state
  logic [7:0] mq[$];
  bit         m_ovf, m_par, m_frm;
  logic [7:0] last_rd = 8'h00;
  int         exp_irq = 0, irq_seen = 0;
  logic       irq_prev = 1'b0;

  typedef struct { int due; logic [7:0] d; } exp_t;
  exp_t eq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {3'b000, m_frm, m_par, m_ovf, mq.size() == DEPTH, mq.size() != 0};
  endfunction

  // compare process: bus completions and interrupt pulse shape
  always @(negedge clk) begin
    if (eq.size() > 0 && eq[0].due == cyc) begin
      chk("data_dv", bus.o_data_DV, 1);
      chk("o_data", bus.o_data, eq[0].d);
      eq.delete(0);
    end else begin
      chk("dv_idle", bus.o_data_DV, 0);
    end
    if (irq === 1'b1) irq_seen++;
    chk("irq_width", irq & irq_prev, 0);
    irq_prev = irq;
  end

  task automatic bus_op(input bit wr, input logic [23:0] a, input logic [7:0] d);
    exp_t e;
    @(posedge clk); #1;
    bus.i_request = 1'b1; bus.i_write = wr; bus.i_address = a; bus.i_data = d;
    if (wr) begin
      if (a == A_CTRL) begin
        if (d[0]) begin m_ovf = 0; m_par = 0; m_frm = 0; end
        if (d[1]) mq.delete();
      end
    end else begin
      if (a == A_DATA) begin
        if (mq.size() > 0) last_rd = mq.pop_front();
        else               last_rd = 8'h00;
      end else if (a == A_STATUS) last_rd = m_status();
      else if (a == A_COUNT)      last_rd = 8'(mq.size());
      else                        last_rd = 8'h00;
    end
    e.due = cyc + 1; e.d = last_rd;
    eq.push_back(e);
    @(posedge clk); #1;
    bus.i_request = 1'b0; bus.i_write = 1'b0;
  endtask

  // read and also pin the value to a hand-computed literal
  task automatic rd_lit(input string nm, input logic [23:0] a, input logic [7:0] lit);
    bus_op(0, a, 8'h00);
    @(negedge clk);
    chk(nm, bus.o_data, lit);
  endtask

  // bit0 start, bits1..8 data LSB-first, bit9 parity, bit10 stop
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input bit pop_at_check);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 ps2_data = f[i];
      repeat (HALF - 1) @(posedge clk);
      #1 ps2_clk = 1'b0;
      if (pop_at_check && i == 10) begin
        // edge seen 3 cycles after the raw fall; this request lands in CHECK
        repeat (2) @(posedge clk);
        bus_op(0, A_DATA, 8'h00);
        repeat (HALF - 4) @(posedge clk);
      end else begin
        repeat (HALF) @(posedge clk);
      end
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    if (nbits == 11) begin
      repeat (6) @(posedge clk);
      if (bad_stop)                m_frm = 1;
      else if (bad_par)            m_par = 1;
      else if (mq.size() == DEPTH) m_ovf = 1;
      else begin mq.push_back(b); exp_irq++; end
      @(negedge clk);
      chk("irq_count", irq_seen, exp_irq);
    end
  endtask

  task automatic model_reset();
    mq.delete(); m_ovf = 0; m_par = 0; m_frm = 0; last_rd = 8'h00; eq.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_request = 1'b0; bus.i_write = 1'b0; bus.i_address = '0; bus.i_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_o_data", bus.o_data, 8'h00);
    chk("rst_dv", bus.o_data_DV, 0);
    chk("rst_irq", irq, 0);
    @(posedge clk); #1 rst = 1'b0;
    rd_lit("status0", A_STATUS, 8'h00);
    rd_lit("count0", A_COUNT, 8'h00);

    // single valid frame
    send_frame(8'h1C, 0, 0, 11, 0);
    chk("irq_1c", irq_seen, 1);
    rd_lit("count_1c", A_COUNT, 8'h01);
    rd_lit("data_1c", A_DATA, 8'h1C);
    rd_lit("count_after_pop", A_COUNT, 8'h00);

    // parity error, then clear
    send_frame(8'hF0, 1, 0, 11, 0);
    rd_lit("status_par", A_STATUS, 8'h08);
    bus_op(1, A_CTRL, 8'h01);
    rd_lit("status_clr", A_STATUS, 8'h00);

    // overflow: 9 frames into 8 entries
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 11, 0);
    chk("irq_ovf", irq_seen, 9);
    rd_lit("status_full", A_STATUS, 8'h07);
    rd_lit("count_full", A_COUNT, 8'h08);
    for (int i = 1; i <= 8; i++) rd_lit("data_seq", A_DATA, 8'(i));
    rd_lit("data_empty", A_DATA, 8'h00);
    rd_lit("status_ovf_sticky", A_STATUS, 8'h04);
    bus_op(1, A_CTRL, 8'h01);

    // timeout after 5 data bits, then a good frame
    send_frame(8'hA5, 0, 0, 6, 0);
    repeat (TMO + 5) @(posedge clk);
    m_frm = 1;
    rd_lit("status_tmo", A_STATUS, 8'h10);
    send_frame(8'h2A, 0, 0, 11, 0);
    rd_lit("data_2a", A_DATA, 8'h2A);
    bus_op(1, A_CTRL, 8'h01);

    // bad stop bit
    send_frame(8'h3C, 0, 1, 11, 0);
    rd_lit("status_stop", A_STATUS, 8'h10);
    bus_op(1, A_CTRL, 8'h01);

    // pop in the same cycle as the CHECK push
    send_frame(8'h11, 0, 0, 11, 0);
    send_frame(8'h22, 0, 0, 11, 0);
    send_frame(8'h33, 0, 0, 11, 0);
    send_frame(8'h44, 0, 0, 11, 1);
    chk("popcheck_head", last_rd, 8'h11);
    rd_lit("count_popcheck", A_COUNT, 8'h03);
    rd_lit("data_22", A_DATA, 8'h22);
    rd_lit("data_33", A_DATA, 8'h33);
    rd_lit("data_44", A_DATA, 8'h44);

    // flush, unmapped/write-only reads
    send_frame(8'h5A, 0, 0, 11, 0);
    bus_op(1, A_CTRL, 8'h02);
    rd_lit("count_flush", A_COUNT, 8'h00);
    bus_op(1, A_DATA, 8'hFF);
    rd_lit("ctrl_read", A_CTRL, 8'h00);
    rd_lit("unmapped", 24'h202004, 8'h00);

    // reset mid-frame with a non-empty FIFO
    send_frame(8'h66, 0, 0, 11, 0);
    rd_lit("count_pre_rst", A_COUNT, 8'h01);
    send_frame(8'h77, 0, 0, 4, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    model_reset();
    @(negedge clk);
    chk("mid_rst_o_data", bus.o_data, 8'h00);
    chk("mid_rst_dv", bus.o_data_DV, 0);
    chk("mid_rst_irq", irq, 0);
    @(posedge clk); #1 rst = 1'b0;
    send_frame(8'h55, 0, 0, 11, 0);
    rd_lit("status_55", A_STATUS, 8'h01);
    rd_lit("data_55", A_DATA, 8'h55);

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
